// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the EX-stage ALU with iterative multiply/divide:
// operation codes, FSM state encoding and the conditional-negate helper.
package alu_muldiv_pkg;

   typedef enum logic [3:0] {
      ALU_OP_ADD   = 4'd0,
      ALU_OP_SUB   = 4'd1,
      ALU_OP_OR    = 4'd2,
      ALU_OP_SLT   = 4'd3,
      ALU_OP_AND   = 4'd4,
      ALU_OP_XOR   = 4'd5,
      ALU_OP_NOR   = 4'd6,
      ALU_OP_SLTU  = 4'd7,
      ALU_OP_MULT  = 4'd8,
      ALU_OP_MULTU = 4'd9,
      ALU_OP_DIV   = 4'd10,
      ALU_OP_DIVU  = 4'd11,
      ALU_OP_MFHI  = 4'd12,
      ALU_OP_MFLO  = 4'd13
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

   // Widest value the negate helper handles; callers zero-extend into it and
   // truncate the result, which is exact for two's-complement negation.
   localparam int unsigned NEG_MAXW = 128;

   // Two's-complement negate when neg is set, pass-through otherwise.
   function automatic logic [NEG_MAXW-1:0] neg_if(input logic [NEG_MAXW-1:0] v,
                                                   input logic                neg);
      logic [NEG_MAXW-1:0] r;
      if (neg) begin
         r = ~v + {{(NEG_MAXW-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_muldiv_muldiv_iter.sv
// Unsigned magnitude engine: WIDTH-step shift-add multiply or restoring
// divide. start_i loads operands; done_o rises once all steps have run.
// Multiply: {hi_o,lo_o} = product. Divide: lo_o = quotient, hi_o = remainder.
module muldiv_iter
   import alu_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] a_mag_i,
   input  logic [WIDTH-1:0] b_mag_i,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] acc_q, acc_d;   // partial product high half / remainder
   logic [WIDTH-1:0] qr_q, qr_d;     // multiplier / dividend shifting into quotient
   logic [WIDTH-1:0] m_q, m_d;       // multiplicand / divisor
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;
   logic             div_q, div_d;

   logic [WIDTH:0]   add_s;
   logic [WIDTH:0]   shl_s;
   logic [WIDTH:0]   diff_s;

   assign done_o = ~run_q & (cnt_q == CNT_W'(WIDTH));
   assign hi_o   = acc_q;
   assign lo_o   = qr_q;

   // One multiply or divide step per cycle while running; load on start.
   always_comb begin
      acc_d = acc_q;
      qr_d  = qr_q;
      m_d   = m_q;
      cnt_d = cnt_q;
      run_d = run_q;
      div_d = div_q;
      add_s  = qr_q[0] ? ({1'b0, acc_q} + {1'b0, m_q}) : {1'b0, acc_q};
      shl_s  = {acc_q, qr_q[WIDTH-1]};
      diff_s = shl_s - {1'b0, m_q};
      if (start_i) begin
         acc_d = {WIDTH{1'b0}};
         qr_d  = a_mag_i;
         m_d   = b_mag_i;
         cnt_d = {CNT_W{1'b0}};
         run_d = 1'b1;
         div_d = is_div_i;
      end else if (run_q) begin
         if (div_q) begin
            // Bit WIDTH of the difference is the borrow: restore on borrow.
            if (diff_s[WIDTH]) begin
               acc_d = shl_s[WIDTH-1:0];
               qr_d  = {qr_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_d = diff_s[WIDTH-1:0];
               qr_d  = {qr_q[WIDTH-2:0], 1'b1};
            end
         end else begin
            acc_d = add_s[WIDTH:1];
            qr_d  = {add_s[0], qr_q[WIDTH-1:1]};
         end
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            run_d = 1'b0;
         end else begin
            run_d = 1'b1;
         end
      end else begin
         run_d = 1'b0;
      end
   end

   // Datapath and step counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= {WIDTH{1'b0}};
         qr_q  <= {WIDTH{1'b0}};
         m_q   <= {WIDTH{1'b0}};
         cnt_q <= {CNT_W{1'b0}};
         run_q <= 1'b0;
         div_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         qr_q  <= qr_d;
         m_q   <= m_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Registered EX-stage ALU: single-cycle integer ops plus iterative signed and
// unsigned multiply/divide into HI/LO behind a valid/ready handshake.
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             ge_than_zero,
   output logic             overflow,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d, lo_q, lo_d, a_hold_q, a_hold_d;
   logic             zero_q, zero_d, ge_q, ge_d, ovalid_q, ovalid_d;
   logic             ovf_q, ovf_d, dbz_q, dbz_d;
   logic             neg_q, neg_d, rem_neg_q, rem_neg_d, bzero_q, bzero_d;
   logic             is_div_q, is_div_d;

   logic [WIDTH-1:0]   res_s, add_s, sub_s, a_mag_s, b_mag_s;
   logic [WIDTH-1:0]   hi_m_s, lo_m_s, quot_fix_s, rem_fix_s;
   logic [2*WIDTH-1:0] prod_fix_s;
   logic               ovf_s, start_s, done_s, div_op_s, signed_op_s;

   assign in_ready     = (state_q == ST_IDLE);
   assign out_valid    = ovalid_q;
   assign out          = out_q;
   assign zero         = zero_q;
   assign ge_than_zero = ge_q;
   assign overflow     = ovf_q;
   assign div_by_zero  = dbz_q;
   assign hi           = hi_q;
   assign lo           = lo_q;

   assign add_s       = a + b;
   assign sub_s       = a - b;
   assign div_op_s    = (op == ALU_OP_DIV) | (op == ALU_OP_DIVU);
   assign signed_op_s = (op == ALU_OP_MULT) | (op == ALU_OP_DIV);
   assign a_mag_s     = WIDTH'(neg_if(NEG_MAXW'(a), signed_op_s & a[WIDTH-1]));
   assign b_mag_s     = WIDTH'(neg_if(NEG_MAXW'(b), signed_op_s & b[WIDTH-1]));
   assign prod_fix_s  = (2*WIDTH)'(neg_if(NEG_MAXW'({hi_m_s, lo_m_s}), neg_q));
   assign quot_fix_s  = WIDTH'(neg_if(NEG_MAXW'(lo_m_s), neg_q));
   assign rem_fix_s   = WIDTH'(neg_if(NEG_MAXW'(hi_m_s), rem_neg_q));

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_s),
      .is_div_i (div_op_s),
      .a_mag_i  (a_mag_s),
      .b_mag_i  (b_mag_s),
      .done_o   (done_s),
      .hi_o     (hi_m_s),
      .lo_o     (lo_m_s)
   );

   // Single-cycle result and signed overflow for the current op.
   always_comb begin
      res_s = {WIDTH{1'b0}};
      ovf_s = 1'b0;
      case (op)
         ALU_OP_ADD: begin
            res_s = add_s;
            ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_OP_SUB: begin
            res_s = sub_s;
            ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_OP_OR:   res_s = a | b;
         ALU_OP_AND:  res_s = a & b;
         ALU_OP_XOR:  res_s = a ^ b;
         ALU_OP_NOR:  res_s = ~(a | b);
         ALU_OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_OP_MFHI: res_s = hi_q;
         ALU_OP_MFLO: res_s = lo_q;
         default:     res_s = {WIDTH{1'b0}};
      endcase
   end

   // Handshake FSM, sign fix-up, HI/LO update and output flags.
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      zero_d    = zero_q;
      ge_d      = ge_q;
      ovalid_d  = 1'b0;
      ovf_d     = 1'b0;
      dbz_d     = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      a_hold_d  = a_hold_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      bzero_d   = bzero_q;
      is_div_d  = is_div_q;
      start_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               case (op)
                  ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU: begin
                     start_s   = 1'b1;
                     state_d   = div_op_s ? ST_DIV : ST_MUL;
                     is_div_d  = div_op_s;
                     neg_d     = signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                     rem_neg_d = signed_op_s & a[WIDTH-1];
                     a_hold_d  = a;
                     bzero_d   = (b == {WIDTH{1'b0}});
                  end
                  default: begin
                     out_d    = res_s;
                     zero_d   = (res_s == {WIDTH{1'b0}});
                     ge_d     = ~res_s[WIDTH-1];
                     ovalid_d = 1'b1;
                     ovf_d    = ovf_s;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL, ST_DIV: begin
            if (done_s) begin
               state_d = ST_FIX;
            end else begin
               state_d = state_q;
            end
         end
         ST_FIX: begin
            if (is_div_q) begin
               if (bzero_q) begin
                  lo_d  = {WIDTH{1'b1}};
                  hi_d  = a_hold_q;
                  dbz_d = 1'b1;
               end else begin
                  lo_d = quot_fix_s;
                  hi_d = rem_fix_s;
               end
            end else begin
               hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
               lo_d = prod_fix_s[WIDTH-1:0];
            end
            out_d    = lo_d;
            zero_d   = (lo_d == {WIDTH{1'b0}});
            ge_d     = ~lo_d[WIDTH-1];
            ovalid_d = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, result, flag and HI/LO registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         out_q     <= {WIDTH{1'b0}};
         zero_q    <= 1'b1;
         ge_q      <= 1'b1;
         ovalid_q  <= 1'b0;
         ovf_q     <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
         a_hold_q  <= {WIDTH{1'b0}};
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         bzero_q   <= 1'b0;
         is_div_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         zero_q    <= zero_d;
         ge_q      <= ge_d;
         ovalid_q  <= ovalid_d;
         ovf_q     <= ovf_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         a_hold_q  <= a_hold_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         bzero_q   <= bzero_d;
         is_div_q  <= is_div_d;
      end
   end

endmodule
